dsi_hs_lane_tx: RTL

//  Single MIPI-DSI data-lane transmitter. Sits directly downstream of the DSI clock generator and runs on dsi_clk.

---
 rtl/dsi_hs_lane_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dsi_hs_lane_tx.sv
// dsi_hs_lane_tx: single MIPI-DSI data-lane transmitter (LP entry, HS burst, LP-11 exit)
// Ports:
//   dsi_clk, dsi_rst_n          lane bit clock, synchronous active-low reset
//   tx_data, tx_valid, tx_last  byte stream from the packet layer, LSB sent first
//   tx_ready                    combinational; a byte is taken when tx_valid & tx_ready
//   lp_dp, lp_dn                LP driver levels
//   hs_en, hs_bit               HS driver enable and serial bit
//   busy                        high whenever the lane is not idle
//   underrun                    one-cycle pulse when a byte boundary finds no data
module dsi_hs_lane_tx #(
    parameter int T_LPX   = 4,
    parameter int T_PREP  = 3,
    parameter int T_ZERO  = 8,
    parameter int T_TRAIL = 4,
    parameter int T_EXIT  = 6,
    parameter int CNT_W   = 8
) (
    input  logic       dsi_clk,
    input  logic       dsi_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       lp_dp,
    output logic       lp_dn,
    output logic       hs_en,
    output logic       hs_bit,
    output logic       busy,
    output logic       underrun
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LPX   = 3'd1;
    localparam logic [2:0] S_PREP  = 3'd2;
    localparam logic [2:0] S_ZERO  = 3'd3;
    localparam logic [2:0] S_SYNC  = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;
    localparam logic [2:0] S_TRAIL = 3'd6;
    localparam logic [2:0] S_EXIT  = 3'd7;
    localparam logic [7:0] SYNC_PAT = 8'hB8;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             last_q, last_d;
    logic             lp_dp_q, lp_dp_d, lp_dn_q, lp_dn_d, hs_en_q, hs_en_d;
    logic             hs_bit_q, hs_bit_d, busy_q, busy_d, underrun_q, underrun_d;
    assign tx_ready = bit_q == 3'd7 && (state_q == S_SYNC || (state_q == S_DATA && !last_q));
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q - CNT_W'(1);
        bit_d      = bit_q;
        sh_d       = sh_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        case (state_q)
            S_IDLE: if (tx_valid) begin
                state_d = S_LPX;
                cnt_d   = CNT_W'(T_LPX - 1);
            end
            S_LPX: if (cnt_q == '0) begin
                state_d = S_PREP;
                cnt_d   = CNT_W'(T_PREP - 1);
            end
            S_PREP: if (cnt_q == '0) begin
                state_d = S_ZERO;
                cnt_d   = CNT_W'(T_ZERO - 1);
            end
            S_ZERO: if (cnt_q == '0) begin
                state_d = S_SYNC;
                bit_d   = 3'd0;
            end
            S_SYNC, S_DATA: begin
                bit_d = bit_q + 3'd1;
                sh_d  = sh_q >> 1;
                // Byte boundary: reload back-to-back (bit_d wraps to 0) or fall into trail.
                if (bit_q == 3'd7) begin
                    if (tx_valid && tx_ready) begin
                        state_d = S_DATA;
                        sh_d    = tx_data;
                        last_d  = tx_last;
                    end else begin
                        state_d    = S_TRAIL;
                        cnt_d      = CNT_W'(T_TRAIL - 1);
                        underrun_d = !(state_q == S_DATA && last_q);
                    end
                end
            end
            S_TRAIL: if (cnt_q == '0) begin
                state_d = S_EXIT;
                cnt_d   = CNT_W'(T_EXIT - 1);
            end
            S_EXIT: if (cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are derived from the next state so they register in step with it.
        lp_dp_d  = state_d == S_IDLE || state_d == S_EXIT;
        lp_dn_d  = lp_dp_d || state_d == S_LPX;
        hs_en_d  = state_d == S_ZERO || state_d == S_SYNC || state_d == S_DATA || state_d == S_TRAIL;
        // Trail holds the inverse of the last HS bit sent before entering it.
        hs_bit_d = state_d == S_SYNC  ? SYNC_PAT[bit_d] :
                   state_d == S_DATA  ? sh_d[0] :
                   state_d == S_TRAIL ? (state_q == S_TRAIL ? hs_bit_q : ~hs_bit_q) : 1'b0;
        busy_d   = state_d != S_IDLE;
    end
    always_ff @(posedge dsi_clk) begin
        if (!dsi_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            sh_q       <= 8'd0;
            last_q     <= 1'b0;
            lp_dp_q    <= 1'b1;
            lp_dn_q    <= 1'b1;
            hs_en_q    <= 1'b0;
            hs_bit_q   <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            last_q     <= last_d;
            lp_dp_q    <= lp_dp_d;
            lp_dn_q    <= lp_dn_d;
            hs_en_q    <= hs_en_d;
            hs_bit_q   <= hs_bit_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end
    assign lp_dp    = lp_dp_q;
    assign lp_dn    = lp_dn_q;
    assign hs_en    = hs_en_q;
    assign hs_bit   = hs_bit_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;
endmodule
